// File: rtl/ex_tracker_if.sv
// Trace element types and the ID->EX->WB handshake bundle for the execute-stage tracker.
package ex_tracker_pkg;

    typedef struct packed {
        logic [31:0] time_start;
        logic [31:0] time_end;
    } stage_time_t;

    typedef struct packed {
        logic        pass_through;
        logic [31:0] instr;
        stage_time_t id_data;
        stage_time_t ex_data;
        stage_time_t wb_data;
    } trace_output;

endpackage

interface ex_tracker_if;
    import ex_tracker_pkg::*;

    logic [31:0] counter;
    logic        id_data_ready;
    trace_output id_data_i;
    logic        is_executing;
    trace_output ex_data_o;
    logic        ex_data_ready;
    logic        queue_overflow;
    logic        exec_underrun;

    modport master (
        output counter, id_data_ready, id_data_i, is_executing,
        input  ex_data_o, ex_data_ready, queue_overflow, exec_underrun
    );

    modport slave (
        input  counter, id_data_ready, id_data_i, is_executing,
        output ex_data_o, ex_data_ready, queue_overflow, exec_underrun
    );

endinterface

// File: rtl/ex_tracker.sv
// Execute-stage trace tracker: queues decode-stage elements, stamps execute start/end
// times from the shared counter and forwards finished elements downstream.
module ex_tracker
    import ex_tracker_pkg::*;
#(
    parameter int PROCESSING_QUEUE_LENGTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    ex_tracker_if.slave  bus
);

    localparam int AW = (PROCESSING_QUEUE_LENGTH > 2) ? $clog2(PROCESSING_QUEUE_LENGTH) : 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(32'd1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(32'd1);
    localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(32'd0);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(PROCESSING_QUEUE_LENGTH);

    typedef enum logic [0:0] {
        EX_IDLE = 1'b0,
        EX_BUSY = 1'b1
    } state_e;

    trace_output   mem_r [PROCESSING_QUEUE_LENGTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          id_ready_q_r;
    logic          exec_q_r;
    state_e        state_r;
    state_e        state_next_s;
    trace_output   work_r;
    trace_output   ex_data_r;
    logic          ex_ready_r;
    logic          overflow_r;
    logic          underrun_r;

    logic          push_s;
    logic          push_ok_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          start_s;
    logic          pass_s;
    logic          finish_s;
    logic          underrun_s;
    trace_output   head_s;
    trace_output   pass_elem_s;
    trace_output   done_elem_s;

    assign push_s    = bus.id_data_ready & ~id_ready_q_r;
    assign full_s    = (count_r == CNT_DEPTH);
    assign empty_s   = (count_r == CNT_ZERO);
    assign push_ok_s = push_s & ~full_s;
    assign head_s    = mem_r[rd_ptr_r];

    // Element shapes leaving the block: squashed elements lose their execute/writeback timing.
    always_comb begin
        pass_elem_s                  = head_s;
        pass_elem_s.ex_data          = stage_time_t'(64'd0);
        pass_elem_s.wb_data          = stage_time_t'(64'd0);
        done_elem_s                  = work_r;
        done_elem_s.ex_data.time_end = bus.counter;
    end

    // Next-state and per-cycle control for the execute FSM.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        start_s      = 1'b0;
        pass_s       = 1'b0;
        finish_s     = 1'b0;
        underrun_s   = 1'b0;
        case (state_r)
            EX_IDLE: begin
                if (!empty_s) begin
                    if (head_s.pass_through) begin
                        pop_s  = 1'b1;
                        pass_s = 1'b1;
                    end else if (bus.is_executing) begin
                        pop_s        = 1'b1;
                        start_s      = 1'b1;
                        state_next_s = EX_BUSY;
                    end else begin
                        state_next_s = EX_IDLE;
                    end
                end else if (bus.is_executing && !exec_q_r) begin
                    underrun_s = 1'b1;
                end else begin
                    state_next_s = EX_IDLE;
                end
            end
            EX_BUSY: begin
                if (!bus.is_executing) begin
                    finish_s     = 1'b1;
                    state_next_s = EX_IDLE;
                end else begin
                    state_next_s = EX_BUSY;
                end
            end
            default: begin
                state_next_s = EX_IDLE;
            end
        endcase
    end

    // FIFO storage, pointers, occupancy and input edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PROCESSING_QUEUE_LENGTH; i++) begin
                mem_r[i] <= trace_output'(225'd0);
            end
            wr_ptr_r     <= AW'(32'd0);
            rd_ptr_r     <= AW'(32'd0);
            count_r      <= CNT_ZERO;
            id_ready_q_r <= 1'b0;
            exec_q_r     <= 1'b0;
        end else begin
            id_ready_q_r <= bus.id_data_ready;
            exec_q_r     <= bus.is_executing;
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= bus.id_data_i;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state, working element and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= EX_IDLE;
            work_r     <= trace_output'(225'd0);
            ex_data_r  <= trace_output'(225'd0);
            ex_ready_r <= 1'b0;
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            ex_ready_r <= pass_s | finish_s;
            if (push_s && full_s) begin
                overflow_r <= 1'b1;
            end
            if (underrun_s) begin
                underrun_r <= 1'b1;
            end
            if (start_s) begin
                work_r                    <= head_s;
                work_r.ex_data.time_start <= bus.counter;
            end
            if (pass_s) begin
                ex_data_r <= pass_elem_s;
            end else if (finish_s) begin
                ex_data_r <= done_elem_s;
            end
        end
    end

    assign bus.ex_data_o      = ex_data_r;
    assign bus.ex_data_ready  = ex_ready_r;
    assign bus.queue_overflow = overflow_r;
    assign bus.exec_underrun  = underrun_r;

endmodule

// File: tb/tb_ex_tracker.sv
// Scoreboard bench for ex_tracker: expected elements are queued as stimulus is driven
// and matched against every ex_data_ready pulse.
module tb_ex_tracker;
    import ex_tracker_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_tracker_if bus();

    ex_tracker #(.PROCESSING_QUEUE_LENGTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          out_cnt  = 0;
    trace_output model_q[$];
    trace_output exp_q[$];
    trace_output last_out;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic trace_output mk_elem(input int id, input bit pt);
        trace_output e;
        e.pass_through       = pt;
        e.instr              = 32'h1000_0000 + 32'(id);
        e.id_data.time_start = 32'(id * 7);
        e.id_data.time_end   = 32'(id * 7 + 3);
        e.ex_data.time_start = 32'hdead_0000 + 32'(id);
        e.ex_data.time_end   = 32'hbeef_0000 + 32'(id);
        e.wb_data.time_start = 32'hcafe_0000 + 32'(id);
        e.wb_data.time_end   = 32'hf00d_0000 + 32'(id);
        return e;
    endfunction

    task automatic push_elem(input trace_output e);
        bus.id_data_i     = e;
        bus.id_data_ready = 1'b1;
        if (model_q.size() < 4) model_q.push_back(e);
        tick();
        bus.id_data_ready = 1'b0;
        tick();
    endtask

    // Holds is_executing for n_high sampled cycles, then one low cycle completes the element.
    task automatic exec_one(input int n_high, input bit with_push, input trace_output pe);
        trace_output head;
        logic [31:0] t_start;
        bus.is_executing = 1'b1;
        t_start = bus.counter;
        head = model_q.pop_front();
        if (with_push) begin
            bus.id_data_i     = pe;
            bus.id_data_ready = 1'b1;
            model_q.push_back(pe);
        end
        tick();
        bus.id_data_ready = 1'b0;
        repeat (n_high - 1) tick();
        bus.is_executing = 1'b0;
        head.ex_data.time_start = t_start;
        head.ex_data.time_end   = bus.counter;
        exp_q.push_back(head);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.is_executing  = 1'b0;
        bus.id_data_ready = 1'b0;
        model_q.delete();
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        bus.counter = 32'd0;
        forever begin
            @(negedge clk);
            bus.counter = bus.counter + 32'd1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bus.ex_data_ready === 1'b1) begin
            out_cnt++;
            last_out = bus.ex_data_o;
            check_eq("expected_pending", 256'(exp_q.size() > 0), 256'(1));
            if (exp_q.size() > 0) check_eq("ex_data_o", 256'(bus.ex_data_o), 256'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          guard;
        trace_output e;
        trace_output z;
        bus.is_executing  = 1'b0;
        bus.id_data_ready = 1'b0;
        bus.id_data_i     = trace_output'(225'd0);
        do_reset();

        check_eq("rst_ready", 256'(bus.ex_data_ready), 256'(0));
        check_eq("rst_data", 256'(bus.ex_data_o), 256'(0));
        check_eq("rst_overflow", 256'(bus.queue_overflow), 256'(0));
        check_eq("rst_underrun", 256'(bus.exec_underrun), 256'(0));

        // Test 1: execute window from counter 10 to 13.
        e = mk_elem(1, 1'b0);
        push_elem(e);
        guard = 0;
        while (bus.counter != 32'd10 && guard < 100) begin
            tick();
            guard++;
        end
        base = out_cnt;
        exec_one(3, 1'b0, e);
        check_eq("t1_pulses", 256'(out_cnt - base), 256'(1));
        check_eq("t1_time_start", 256'(last_out.ex_data.time_start), 256'(10));
        check_eq("t1_time_end", 256'(last_out.ex_data.time_end), 256'(13));
        check_eq("t1_id_data", 256'(last_out.id_data), 256'(e.id_data));

        // Test 2: pass-through element with nonzero ex_data.
        e = mk_elem(2, 1'b1);
        z = e;
        z.ex_data = stage_time_t'(64'd0);
        z.wb_data = stage_time_t'(64'd0);
        exp_q.push_back(z);
        base = out_cnt;
        bus.id_data_i     = e;
        bus.id_data_ready = 1'b1;
        tick();
        check_eq("t2_no_early_pulse", 256'(bus.ex_data_ready), 256'(0));
        bus.id_data_ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t2_pulse_latency", 256'(bus.ex_data_ready), 256'(1));
        tick();
        check_eq("t2_ex_zero", 256'(last_out.ex_data), 256'(0));
        check_eq("t2_wb_zero", 256'(last_out.wb_data), 256'(0));

        // Test 3: overflow on the fifth push, then four in-order executions.
        for (int i = 0; i < 5; i++) begin
            push_elem(mk_elem(30 + i, 1'b0));
            if (i == 3) check_eq("t3_no_overflow_at_4", 256'(bus.queue_overflow), 256'(0));
        end
        check_eq("t3_overflow", 256'(bus.queue_overflow), 256'(1));
        base = out_cnt;
        for (int i = 0; i < 4; i++) exec_one(1 + (i % 3), 1'b0, e);
        repeat (4) tick();
        check_eq("t3_out_count", 256'(out_cnt - base), 256'(4));
        check_eq("t3_drained", 256'(exp_q.size()), 256'(0));
        check_eq("t3_no_underrun", 256'(bus.exec_underrun), 256'(0));

        // Test 4: simultaneous push and start at count 2, then wrap pointers.
        do_reset();
        push_elem(mk_elem(40, 1'b0));
        push_elem(mk_elem(41, 1'b0));
        exec_one(2, 1'b1, mk_elem(42, 1'b0));
        push_elem(mk_elem(43, 1'b0));
        push_elem(mk_elem(44, 1'b0));
        check_eq("t4_count_held", 256'(bus.queue_overflow), 256'(0));
        push_elem(mk_elem(45, 1'b0));
        check_eq("t4_full_at_4", 256'(bus.queue_overflow), 256'(1));
        for (int i = 0; i < 4; i++) exec_one(1, 1'b0, e);
        for (int i = 0; i < 3; i++) begin
            push_elem(mk_elem(46 + i, 1'b0));
            exec_one(2, 1'b0, e);
        end
        repeat (3) tick();
        check_eq("t4_drained", 256'(exp_q.size()), 256'(0));

        // Test 5: execution with nothing queued.
        check_eq("t5_underrun_clear", 256'(bus.exec_underrun), 256'(0));
        base = out_cnt;
        bus.is_executing = 1'b1;
        tick();
        bus.is_executing = 1'b0;
        tick();
        check_eq("t5_underrun_set", 256'(bus.exec_underrun), 256'(1));
        check_eq("t5_no_pulse", 256'(out_cnt - base), 256'(0));
        push_elem(mk_elem(50, 1'b0));
        exec_one(2, 1'b0, e);
        tick();
        check_eq("t5_underrun_sticky", 256'(bus.exec_underrun), 256'(1));

        // Test 6: asynchronous reset while busy with two queued elements.
        push_elem(mk_elem(60, 1'b0));
        push_elem(mk_elem(61, 1'b0));
        push_elem(mk_elem(62, 1'b0));
        bus.is_executing = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_ready", 256'(bus.ex_data_ready), 256'(0));
        check_eq("t6_rst_data", 256'(bus.ex_data_o), 256'(0));
        check_eq("t6_rst_overflow", 256'(bus.queue_overflow), 256'(0));
        check_eq("t6_rst_underrun", 256'(bus.exec_underrun), 256'(0));
        bus.is_executing = 1'b0;
        model_q.delete();
        exp_q.delete();
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        base = out_cnt;
        e = mk_elem(70, 1'b0);
        push_elem(e);
        exec_one(2, 1'b0, e);
        repeat (4) tick();
        check_eq("t6_only_new", 256'(out_cnt - base), 256'(1));
        check_eq("t6_new_id", 256'(last_out.id_data), 256'(e.id_data));
        check_eq("final_drained", 256'(exp_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
